// File: rtl/yabot_host_pkg.sv
// Shared constants and state types for the yabot host emulator: command IDs,
// frame geometry, and the SPI-master and echo-channel state encodings.
package yabot_host_pkg;

    localparam int FRAME_W = 32;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 28;

    localparam logic [ID_W-1:0] ID_NOP        = 4'd0;
    localparam logic [ID_W-1:0] ID_SONARS     = 4'd1;
    localparam logic [ID_W-1:0] ID_MOTOR      = 4'd2;
    localparam logic [ID_W-1:0] ID_ADC        = 4'd3;
    localparam logic [ID_W-1:0] ID_RADIO      = 4'd4;
    localparam logic [ID_W-1:0] ID_REMOTECTRL = 4'd5;
    localparam logic [ID_W-1:0] ID_SERVO      = 4'd13;
    localparam logic [ID_W-1:0] ID_OUTGPIO    = 4'd14;
    localparam logic [ID_W-1:0] ID_POWEROFF   = 4'd15;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_SETUP,
        SPI_SHIFT,
        SPI_HOLD,
        SPI_GAP
    } spi_state_t;

    typedef enum logic [1:0] {
        EC_IDLE,
        EC_WAIT,
        EC_HIGH
    } echo_state_t;

    function automatic logic id_is_defined(input logic [ID_W-1:0] id);
        return (id == ID_NOP)    || (id == ID_SONARS) || (id == ID_MOTOR)      ||
               (id == ID_ADC)    || (id == ID_RADIO)  || (id == ID_REMOTECTRL) ||
               (id == ID_SERVO)  || (id == ID_OUTGPIO) || (id == ID_POWEROFF);
    endfunction

endpackage

// File: rtl/host_spi_master.sv
// Jetson-side SPI master (mode 0, MSB first, 32-bit full duplex) that also
// compares each received frame against the word latched at accept.
module host_spi_master
    import yabot_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [ID_W-1:0]    tx_id,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               chk_en,
    input  logic [ID_W-1:0]    exp_id,
    input  logic [DATA_W-1:0]  exp_data,
    output logic               rx_valid,
    output logic [FRAME_W-1:0] rx_word,
    output logic               err,
    output logic               spi_sclk,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               spi_cs
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP + 1);

    spi_state_t         r_state, w_state_next;
    logic [DIV_W-1:0]   r_div;
    logic [5:0]         r_half;
    logic [GAP_W-1:0]   r_gap;
    logic [FRAME_W-1:0] r_tx, r_rx, r_exp, r_rx_word;
    logic               r_chk, r_sclk, r_cs, r_rx_valid, r_err;
    logic               w_div_end;

    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) r_state <= SPI_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        tx_ready     = (r_state == SPI_IDLE);
        case (r_state)
            SPI_IDLE:  if (tx_valid) w_state_next = SPI_SETUP;
            SPI_SETUP: if (w_div_end) w_state_next = SPI_SHIFT;
            SPI_SHIFT: if (w_div_end && r_half == 6'd63) w_state_next = SPI_HOLD;
            SPI_HOLD:  if (w_div_end) w_state_next = SPI_GAP;
            SPI_GAP:   if (r_gap == GAP_W'(CS_GAP - 1)) w_state_next = SPI_IDLE;
            default:   w_state_next = SPI_IDLE;
        endcase
    end

    // SHIFT spans 64 half-periods; the last low half drives no new rise
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_half     <= '0;
            r_gap      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_exp      <= '0;
            r_rx_word  <= '0;
            r_chk      <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_div      <= (r_state == SPI_IDLE || w_div_end) ? '0 : r_div + DIV_W'(1);
            case (r_state)
                SPI_IDLE: if (tx_valid) begin
                    r_tx   <= {tx_id, tx_data};
                    r_exp  <= {exp_id, exp_data};
                    r_chk  <= chk_en;
                    r_cs   <= 1'b0;
                    r_half <= '0;
                end
                SPI_SETUP: if (w_div_end) begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[FRAME_W-2:0], spi_miso};
                end
                SPI_SHIFT: if (w_div_end) begin
                    r_half <= r_half + 6'd1;
                    if (r_sclk) begin
                        r_sclk <= 1'b0;
                        r_tx   <= {r_tx[FRAME_W-2:0], 1'b0};
                    end else if (r_half != 6'd63) begin
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[FRAME_W-2:0], spi_miso};
                    end
                end
                SPI_HOLD: if (w_div_end) begin
                    r_cs       <= 1'b1;
                    r_rx_valid <= 1'b1;
                    r_rx_word  <= r_rx;
                    r_err      <= r_chk && (r_rx != r_exp);
                    r_gap      <= '0;
                end
                SPI_GAP: r_gap <= r_gap + GAP_W'(1);
                default: ;
            endcase
        end
    end

    assign spi_sclk = r_sclk;
    assign spi_mosi = r_tx[FRAME_W-1];
    assign spi_cs   = r_cs;
    assign rx_valid = r_rx_valid;
    assign rx_word  = r_rx_word;
    assign err      = r_err;

endmodule

// File: rtl/yabot_host_emulator.sv
// Host-side stand-in for yabot_top: SPI command master, button pulsers and sonar
// echo responders. Define HOST_EMU_ERRCNT_EN to add err_cnt/err_sticky outputs.
module yabot_host_emulator
    import yabot_host_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 8,
    parameter int NUM_BTN    = 4,
    parameter int NUM_ECHO   = 6,
    parameter int ECHO_DELAY = 50,
    parameter int TRIG_MIN   = 100
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [ID_W-1:0]     tx_id,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                chk_en,
    input  logic [ID_W-1:0]     exp_id,
    input  logic [DATA_W-1:0]   exp_data,
    output logic                rx_valid,
    output logic [FRAME_W-1:0]  rx_word,
    output logic                err,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic                spi_cs,
    input  logic [NUM_BTN-1:0]  btn_start,
    input  logic [23:0]         btn_len,
    output logic [NUM_BTN-1:0]  btn,
    input  logic [15:0]         echo_len,
    input  logic [NUM_ECHO-1:0] trig,
    output logic [NUM_ECHO-1:0] echo
`ifdef HOST_EMU_ERRCNT_EN
    ,
    output logic [15:0]         err_cnt,
    output logic                err_sticky
`endif
);

    host_spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_spi (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_id    (tx_id),
        .tx_data  (tx_data),
        .chk_en   (chk_en),
        .exp_id   (exp_id),
        .exp_data (exp_data),
        .rx_valid (rx_valid),
        .rx_word  (rx_word),
        .err      (err),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs   (spi_cs)
    );

`ifdef HOST_EMU_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        r_err_sticky;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (err) begin
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            r_err_sticky <= 1'b1;
        end
    end

    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [23:0] r_cnt;

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n)                r_cnt <= '0;
            else if (btn_start[i])     r_cnt <= btn_len;
            else if (r_cnt != '0)      r_cnt <= r_cnt - 24'd1;
        end

        assign btn[i] = (r_cnt != '0);
    end

    // Triggers seen while waiting or echoing are dropped by clearing the high count
    for (genvar e = 0; e < NUM_ECHO; e++) begin : g_echo
        echo_state_t r_state, w_state_next;
        logic        r_trig_d;
        logic [15:0] r_high, r_delay, r_width;
        logic        w_rise, w_fall, w_arm;

        assign w_rise = trig[e] & ~r_trig_d;
        assign w_fall = ~trig[e] & r_trig_d;
        assign w_arm  = (r_state == EC_IDLE) && w_fall &&
                        (r_high >= 16'(TRIG_MIN)) && (echo_len != '0);

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) r_state <= EC_IDLE;
            else        r_state <= w_state_next;
        end

        always_comb begin
            w_state_next = r_state;
            case (r_state)
                EC_IDLE: if (w_arm) w_state_next = EC_WAIT;
                EC_WAIT: if (r_delay == 16'(ECHO_DELAY - 1)) w_state_next = EC_HIGH;
                EC_HIGH: if (r_width == 16'd1) w_state_next = EC_IDLE;
                default: w_state_next = EC_IDLE;
            endcase
        end

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_trig_d <= 1'b0;
                r_high   <= '0;
                r_delay  <= '0;
                r_width  <= '0;
            end else begin
                r_trig_d <= trig[e];
                if (r_state != EC_IDLE || w_fall)
                    r_high <= '0;
                else if (w_rise)
                    r_high <= 16'd1;
                else if (trig[e] && r_high != '0 && r_high < 16'(TRIG_MIN))
                    r_high <= r_high + 16'd1;

                if (w_arm) begin
                    r_delay <= 16'd1;
                    r_width <= echo_len;
                end else if (r_state == EC_WAIT) begin
                    r_delay <= r_delay + 16'd1;
                end else if (r_state == EC_HIGH) begin
                    r_width <= r_width - 16'd1;
                end
            end
        end

        assign echo[e] = (r_state == EC_HIGH);
    end

endmodule

// File: tb/tb_yabot_host_emulator.sv
// Directed self-checking bench for yabot_host_emulator with a mode-0 SPI slave model.
module tb_yabot_host_emulator;
    import yabot_host_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int CS_GAP     = 8;
    localparam int NUM_BTN    = 4;
    localparam int NUM_ECHO   = 6;
    localparam int ECHO_DELAY = 50;
    localparam int TRIG_MIN   = 100;
    localparam int RX_CYC     = 66 * CLK_DIV;
    localparam int FRAME_CYC  = 66 * CLK_DIV + CS_GAP;

    logic                clk_in = 1'b0;
    logic                rst_n;
    logic                tx_valid, tx_ready, chk_en;
    logic [ID_W-1:0]     tx_id, exp_id;
    logic [DATA_W-1:0]   tx_data, exp_data;
    logic                rx_valid, err;
    logic [FRAME_W-1:0]  rx_word;
    logic                spi_sclk, spi_mosi, spi_miso, spi_cs;
    logic [NUM_BTN-1:0]  btn_start, btn;
    logic [23:0]         btn_len;
    logic [15:0]         echo_len;
    logic [NUM_ECHO-1:0] trig, echo;
`ifdef HOST_EMU_ERRCNT_EN
    logic [15:0]         err_cnt;
    logic                err_sticky;
`endif

    int          nCmp = 0;
    int          nFail = 0;
    int          fallCnt = 0;
    logic [31:0] slvReply = '0;
    logic [31:0] mosiCap = '0;
    int          cyc, n;
    logic [NUM_ECHO-1:0] seenEcho;
    logic [2:0]  otherBtn;
    logic        seenRx;

    yabot_host_emulator #(
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP),
        .NUM_BTN    (NUM_BTN),
        .NUM_ECHO   (NUM_ECHO),
        .ECHO_DELAY (ECHO_DELAY),
        .TRIG_MIN   (TRIG_MIN)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_id     (tx_id),
        .tx_data   (tx_data),
        .chk_en    (chk_en),
        .exp_id    (exp_id),
        .exp_data  (exp_data),
        .rx_valid  (rx_valid),
        .rx_word   (rx_word),
        .err       (err),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs    (spi_cs),
        .btn_start (btn_start),
        .btn_len   (btn_len),
        .btn       (btn),
        .echo_len  (echo_len),
        .trig      (trig),
        .echo      (echo)
`ifdef HOST_EMU_ERRCNT_EN
        ,
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Slave presents bit 31 when CS drops and the next bit on every SCLK fall
    always @(negedge spi_sclk or posedge spi_cs) begin
        if (spi_cs) fallCnt = 0;
        else        fallCnt = fallCnt + 1;
    end

    assign spi_miso = (fallCnt < 32) ? slvReply[31 - fallCnt] : 1'b0;

    always @(posedge spi_sclk) mosiCap = {mosiCap[30:0], spi_mosi};

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCmp++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Launches a frame (tx_valid held 1+hold cycles), then scrambles the compare
    // inputs so only the values latched at accept can matter; returns cycles to rx_valid
    task automatic applyStimulus(input logic [3:0] id, input logic [27:0] data,
                                 input logic chk, input logic [3:0] eid,
                                 input logic [27:0] edata, input int hold,
                                 output int rxCyc);
        tx_id    = id;
        tx_data  = data;
        chk_en   = chk;
        exp_id   = eid;
        exp_data = edata;
        tx_valid = 1'b1;
        tick(1);
        rxCyc = 0;
        if (hold > 0) begin
            tick(hold);
            rxCyc = hold;
        end
        tx_valid = 1'b0;
        chk_en   = ~chk;
        exp_data = ~edata;
        while (!rx_valid && rxCyc < 400) begin
            tick(1);
            rxCyc++;
        end
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        while (!tx_ready && cycles < 100) begin
            tick(1);
            cycles++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_id     = '0;
        tx_data   = '0;
        chk_en    = 1'b0;
        exp_id    = '0;
        exp_data  = '0;
        btn_start = '0;
        btn_len   = '0;
        echo_len  = 16'd450;
        trig      = '0;
        #23;

        $display("[TB] reset state");
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_spi_cs", 32'(spi_cs), 32'd1);
        checkOutput("rst_spi_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("rst_spi_mosi", 32'(spi_mosi), 32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_rx_word", rx_word, 32'd0);
        checkOutput("rst_btn", 32'(btn), 32'd0);
        checkOutput("rst_echo", 32'(echo), 32'd0);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] SPI frame with matching compare");
        slvReply = 32'h0100_0000;
        applyStimulus(ID_OUTGPIO, 28'd1, 1'b1, ID_NOP, 28'h100_0000, 5, cyc);
        checkOutput("frame_rx_cycle", 32'(cyc), 32'(RX_CYC));
        checkOutput("frame_rx_word", rx_word, 32'h0100_0000);
        checkOutput("frame_mosi_stream", mosiCap, 32'hE000_0001);
        checkOutput("frame_err", 32'(err), 32'd0);
        checkOutput("frame_cs_end", 32'(spi_cs), 32'd1);
        tick(1);
        checkOutput("frame_rx_pulse", 32'(rx_valid), 32'd0);
        waitReady(n);
        checkOutput("frame_ready_cycle", 32'(cyc + 1 + n), 32'(FRAME_CYC));
        tick(3);
        checkOutput("busy_request_dropped", 32'(spi_cs), 32'd1);
`ifdef HOST_EMU_ERRCNT_EN
        checkOutput("frame_err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("[TB] SPI frame with compare mismatch");
        slvReply = 32'h0F00_0000;
        applyStimulus(ID_ADC, 28'h000_0ABC, 1'b1, ID_NOP, 28'hB00_0000, 0, cyc);
        checkOutput("mismatch_rx_cycle", 32'(cyc), 32'(RX_CYC));
        checkOutput("mismatch_rx_word", rx_word, 32'h0F00_0000);
        checkOutput("mismatch_mosi", mosiCap, 32'h3000_0ABC);
        checkOutput("mismatch_err", 32'(err), 32'd1);
        tick(1);
        checkOutput("mismatch_err_pulse", 32'(err), 32'd0);
`ifdef HOST_EMU_ERRCNT_EN
        checkOutput("mismatch_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("mismatch_err_sticky", 32'(err_sticky), 32'd1);
`endif
        waitReady(n);
        checkOutput("mismatch_ready_cycle", 32'(cyc + 1 + n), 32'(FRAME_CYC));

        $display("[TB] mismatch with compare disabled");
        applyStimulus(ID_RADIO, 28'h123_4567, 1'b0, ID_NOP, 28'hB00_0000, 0, cyc);
        checkOutput("nochk_rx_word", rx_word, 32'h0F00_0000);
        checkOutput("nochk_err", 32'(err), 32'd0);
`ifdef HOST_EMU_ERRCNT_EN
        checkOutput("nochk_err_cnt", 32'(err_cnt), 32'd1);
`endif
        tick(1);
        waitReady(n);

        $display("[TB] reset during SHIFT");
        tx_id    = ID_MOTOR;
        tx_data  = 28'h555_5555;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(40);
        checkOutput("midframe_cs_low", 32'(spi_cs), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_cs", 32'(spi_cs), 32'd1);
        checkOutput("midrst_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("midrst_tx_ready", 32'(tx_ready), 32'd1);
`ifdef HOST_EMU_ERRCNT_EN
        checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("midrst_err_sticky", 32'(err_sticky), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        seenRx = 1'b0;
        repeat (300) begin
            tick(1);
            seenRx |= rx_valid;
        end
        checkOutput("midrst_no_rx_valid", 32'(seenRx), 32'd0);

        $display("[TB] button pulses");
        btn_len   = 24'd1525;
        btn_start = 4'b0001;
        tick(1);
        btn_start = '0;
        n = 0;
        otherBtn = '0;
        while (btn[0] && n < 3000) begin
            n++;
            otherBtn |= btn[3:1];
            tick(1);
        end
        checkOutput("btn0_width", 32'(n), 32'd1525);
        checkOutput("btn_others_idle", 32'(otherBtn), 32'd0);
        btn_len   = 24'd0;
        btn_start = 4'b0010;
        tick(1);
        btn_start = '0;
        checkOutput("btn_len0_none", 32'(btn), 32'd0);
        btn_len   = 24'd10;
        btn_start = 4'b0100;
        tick(1);
        btn_start = '0;
        tick(4);
        btn_start = 4'b0100;
        tick(1);
        btn_start = '0;
        n = 0;
        while (btn[2] && n < 100) begin
            n++;
            tick(1);
        end
        checkOutput("btn2_restart_width", 32'(n), 32'd10);

        $display("[TB] trig length boundary and latched width");
        trig = 6'b000011;
        tick(99);
        trig = 6'b000010;
        tick(1);
        trig = '0;
        tick(2);
        echo_len = 16'd7;
        tick(47);
        checkOutput("min_before_delay", 32'(echo), 32'd0);
        tick(1);
        checkOutput("min_echo_rise", 32'(echo), 32'b000010);
        tick(449);
        checkOutput("min_echo_last", 32'(echo), 32'b000010);
        tick(1);
        checkOutput("min_echo_fall", 32'(echo), 32'd0);
        echo_len = 16'd450;

        $display("[TB] single channel echo");
        trig = 6'b000100;
        tick(200);
        trig = '0;
        n = 0;
        while (!echo[2] && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("ch2_delay", 32'(n), 32'(ECHO_DELAY));
        cyc = 0;
        while (echo[2] && cyc < 1000) begin
            cyc++;
            tick(1);
        end
        checkOutput("ch2_width", 32'(cyc), 32'd450);
        trig = 6'b000100;
        tick(50);
        trig = '0;
        seenEcho = '0;
        repeat (300) begin
            tick(1);
            seenEcho |= echo;
        end
        checkOutput("short_trig_ignored", 32'(seenEcho), 32'd0);

        $display("[TB] simultaneous triggers");
        trig = 6'h3F;
        tick(150);
        trig = '0;
        tick(49);
        checkOutput("all_before_delay", 32'(echo), 32'h00);
        tick(1);
        checkOutput("all_echo_rise", 32'(echo), 32'h3F);
        tick(49);
        checkOutput("all_echo_mid", 32'(echo), 32'h3F);
        trig = 6'h3F;
        tick(400);
        checkOutput("all_echo_last", 32'(echo), 32'h3F);
        tick(1);
        checkOutput("all_echo_fall", 32'(echo), 32'h00);
        tick(50);
        trig = '0;
        seenEcho = '0;
        repeat (300) begin
            tick(1);
            seenEcho |= echo;
        end
        checkOutput("retrig_during_echo_ignored", 32'(seenEcho), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
